// File: rtl/fp32_pkg.sv
// Shared constants, FSM state encoding and operand classes for the binary32 divider.
package fp32_pkg;

  localparam int BIAS      = 127;
  localparam int EXP_W     = 8;
  localparam int MAN_W     = 23;
  localparam int DIV_ITERS = 26;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_DIV   = 3'd2,
    ST_ROUND = 3'd3,
    ST_DONE  = 3'd4
  } fsm_state_e;

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_NORMAL = 3'd1,
    CLS_INF    = 3'd2,
    CLS_QNAN   = 3'd3,
    CLS_SNAN   = 3'd4
  } fp_class_e;

endpackage

// File: rtl/fp32_unpack.sv
// Classifies one binary32 operand and expands its significand with the hidden bit.
// Denormals are reported as signed zero.
module fp32_unpack
  import fp32_pkg::*;
(
  input  logic [31:0]      op_i,
  output logic             sign_o,
  output logic [EXP_W-1:0] exp_o,
  output logic [MAN_W:0]   man_o,
  output logic [2:0]       cls_o
);

  // field split and classification
  always_comb begin
    sign_o = op_i[31];
    exp_o  = op_i[30:23];
    man_o  = 24'd0;
    cls_o  = CLS_ZERO;
    if (op_i[30:23] == 8'd0) begin
      exp_o = 8'd0;
      cls_o = CLS_ZERO;
    end else if (op_i[30:23] == 8'hFF) begin
      if (op_i[22:0] == 23'd0) begin
        cls_o = CLS_INF;
      end else if (op_i[22]) begin
        cls_o = CLS_QNAN;
      end else begin
        cls_o = CLS_SNAN;
      end
    end else begin
      cls_o = CLS_NORMAL;
      man_o = {1'b1, op_i[22:0]};
    end
  end

endmodule

// File: rtl/fp32_divider.sv
// Multi-cycle binary32 divider: restoring radix-2 significand division, round-to-nearest-even,
// flush-to-zero on underflow, fixed 30-cycle operation regardless of operand class.
module fp32_divider
  import fp32_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result_o,
  output logic        done_o,
  output logic        overflow_o,
  output logic        underflow_o,
  output logic        invalid_o,
  output logic        divzero_o
);

  fsm_state_e         state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [24:0]        rem_q, rem_d;
  logic [23:0]        dvs_q, dvs_d;
  logic [25:0]        quot_q, quot_d;
  logic signed [9:0]  exp_q, exp_d;
  logic               sign_q, sign_d;
  logic               spec_q, spec_d;
  logic [31:0]        spec_res_q, spec_res_d;
  logic [3:0]         spec_flags_q, spec_flags_d;
  logic [31:0]        pend_res_q, pend_res_d;
  logic [3:0]         pend_flags_q, pend_flags_d;
  logic [31:0]        res_q, res_d;
  logic [3:0]         flags_q, flags_d;   // {overflow, underflow, invalid, divzero}

  logic               sign_a_s, sign_b_s;
  logic [7:0]         exp_a_s, exp_b_s;
  logic [23:0]        man_a_s, man_b_s;
  logic [2:0]         cls_a_s, cls_b_s;

  fp32_unpack u_unpack_a (.op_i(a_q), .sign_o(sign_a_s), .exp_o(exp_a_s), .man_o(man_a_s), .cls_o(cls_a_s));
  fp32_unpack u_unpack_b (.op_i(b_q), .sign_o(sign_b_s), .exp_o(exp_b_s), .man_o(man_b_s), .cls_o(cls_b_s));

  logic               prep_shift_s;
  logic [24:0]        prep_rem_s;
  logic signed [9:0]  prep_exp_s;
  logic               q_sign_s;
  logic               spec_hit_s;
  logic [31:0]        spec_res_s;
  logic [3:0]         spec_flags_s;

  // operand alignment, exponent difference and special-case override
  always_comb begin
    q_sign_s     = sign_a_s ^ sign_b_s;
    prep_shift_s = (man_a_s < man_b_s);
    prep_rem_s   = prep_shift_s ? {man_a_s, 1'b0} : {1'b0, man_a_s};
    prep_exp_s   = {2'b00, exp_a_s} - {2'b00, exp_b_s} + 10'(BIAS) - {9'd0, prep_shift_s};
    spec_hit_s   = 1'b1;
    spec_res_s   = 32'd0;
    spec_flags_s = 4'b0000;
    if ((cls_a_s == CLS_QNAN) || (cls_a_s == CLS_SNAN) || (cls_b_s == CLS_QNAN) || (cls_b_s == CLS_SNAN)) begin
      spec_res_s   = QNAN;
      spec_flags_s = {2'b00, (cls_a_s == CLS_SNAN) || (cls_b_s == CLS_SNAN), 1'b0};
    end else if (((cls_a_s == CLS_ZERO) && (cls_b_s == CLS_ZERO)) ||
                 ((cls_a_s == CLS_INF) && (cls_b_s == CLS_INF))) begin
      spec_res_s   = QNAN;
      spec_flags_s = 4'b0010;
    end else if (cls_a_s == CLS_INF) begin
      spec_res_s   = {q_sign_s, POS_INF[30:0]};
    end else if (cls_b_s == CLS_ZERO) begin
      spec_res_s   = {q_sign_s, POS_INF[30:0]};
      spec_flags_s = 4'b0001;
    end else if ((cls_b_s == CLS_INF) || (cls_a_s == CLS_ZERO)) begin
      spec_res_s   = {q_sign_s, 31'd0};
    end else begin
      spec_hit_s   = 1'b0;
    end
  end

  logic               div_ge_s;
  logic [23:0]        div_sub_s;

  // one restoring-division step
  always_comb begin
    div_ge_s  = (rem_q >= {1'b0, dvs_q});
    div_sub_s = div_ge_s ? 24'(rem_q - {1'b0, dvs_q}) : rem_q[23:0];
  end

  logic               rnd_up_s;
  logic [24:0]        mant_rnd_s;
  logic signed [9:0]  exp_fin_s;
  logic [22:0]        frac_s;
  logic [31:0]        rnd_res_s;
  logic [3:0]         rnd_flags_s;

  // quotient layout: [25] integer bit, [24:2] fraction, [1] guard, [0] round; sticky from remainder
  always_comb begin
    rnd_up_s    = quot_q[1] & (quot_q[0] | (|rem_q) | quot_q[2]);
    mant_rnd_s  = {1'b0, quot_q[25:2]} + {24'd0, rnd_up_s};
    exp_fin_s   = exp_q + $signed({9'd0, mant_rnd_s[24]});
    frac_s      = mant_rnd_s[24] ? mant_rnd_s[23:1] : mant_rnd_s[22:0];
    rnd_res_s   = {sign_q, exp_fin_s[7:0], frac_s};
    rnd_flags_s = 4'b0000;
    if (spec_q) begin
      rnd_res_s   = spec_res_q;
      rnd_flags_s = spec_flags_q;
    end else if (exp_fin_s >= 10'sd255) begin
      rnd_res_s   = {sign_q, POS_INF[30:0]};
      rnd_flags_s = 4'b1000;
    end else if (exp_fin_s <= 10'sd0) begin
      rnd_res_s   = {sign_q, 31'd0};
      rnd_flags_s = 4'b0100;
    end else begin
      rnd_flags_s = 4'b0000;
    end
  end

  // FSM sequencing and datapath next-state
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    rem_d        = rem_q;
    dvs_d        = dvs_q;
    quot_d       = quot_q;
    exp_d        = exp_q;
    sign_d       = sign_q;
    spec_d       = spec_q;
    spec_res_d   = spec_res_q;
    spec_flags_d = spec_flags_q;
    pend_res_d   = pend_res_q;
    pend_flags_d = pend_flags_q;
    res_d        = res_q;
    flags_d      = flags_q;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_i && ready_q) begin
          state_d = ST_PREP;
          a_d     = A;
          b_d     = B;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PREP: begin
        state_d      = ST_DIV;
        cnt_d        = 5'd0;
        rem_d        = prep_rem_s;
        dvs_d        = man_b_s;
        quot_d       = 26'd0;
        exp_d        = prep_exp_s;
        sign_d       = q_sign_s;
        spec_d       = spec_hit_s;
        spec_res_d   = spec_res_s;
        spec_flags_d = spec_flags_s;
      end
      ST_DIV: begin
        quot_d = {quot_q[24:0], div_ge_s};
        rem_d  = {div_sub_s, 1'b0};
        if (cnt_q == 5'(DIV_ITERS - 1)) begin
          state_d = ST_ROUND;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_ROUND: begin
        state_d      = ST_DONE;
        pend_res_d   = rnd_res_s;
        pend_flags_d = rnd_flags_s;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        res_d   = pend_res_q;
        flags_d = pend_flags_q;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // state and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 5'd0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      rem_q        <= 25'd0;
      dvs_q        <= 24'd0;
      quot_q       <= 26'd0;
      exp_q        <= 10'sd0;
      sign_q       <= 1'b0;
      spec_q       <= 1'b0;
      spec_res_q   <= 32'd0;
      spec_flags_q <= 4'd0;
      pend_res_q   <= 32'd0;
      pend_flags_q <= 4'd0;
      res_q        <= 32'd0;
      flags_q      <= 4'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rem_q        <= rem_d;
      dvs_q        <= dvs_d;
      quot_q       <= quot_d;
      exp_q        <= exp_d;
      sign_q       <= sign_d;
      spec_q       <= spec_d;
      spec_res_q   <= spec_res_d;
      spec_flags_q <= spec_flags_d;
      pend_res_q   <= pend_res_d;
      pend_flags_q <= pend_flags_d;
      res_q        <= res_d;
      flags_q      <= flags_d;
    end
  end

  assign ready_o     = ready_q;
  assign done_o      = done_q;
  assign result_o    = res_q;
  assign overflow_o  = flags_q[3];
  assign underflow_o = flags_q[2];
  assign invalid_o   = flags_q[1];
  assign divzero_o   = flags_q[0];

endmodule

// File: doc/fp32_divider.md
FP32_DIVIDER -- requirements
Module: fp32_divider

Interface
REQ-001 The block SHALL use one clock and one reset; the reset is synchronous and active-high.
REQ-002 clk_i  input  1  clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  synchronous active-high reset.
REQ-004 valid_i  input  1  operand request; accepted only when ready_o=1.
REQ-005 ready_o  output  1  high only in IDLE.
REQ-006 A  input  32  dividend, IEEE-754 binary32.
REQ-007 B  input  32  divisor, IEEE-754 binary32.
REQ-008 result_o  output  32  quotient A/B.
REQ-009 done_o  output  1  one-cycle pulse; result_o and flags are valid in that cycle.
REQ-010 overflow_o, underflow_o, invalid_o, divzero_o  output  1 each  exception flags, qualified by done_o.

Function
REQ-011 FSM states: IDLE, PREP, DIV, ROUND, DONE.
- IDLE->PREP on an edge with valid_i&&ready_o (the accepting edge E0); A and B are captured at E0.
- PREP->DIV after 1 cycle.
- DIV->ROUND after exactly 26 cycles.
- ROUND->DONE after 1 cycle.
- DONE->IDLE after 1 cycle.
REQ-012 Latency SHALL be fixed for all operand classes: done_o is high in the cycle following edge E0+29, for exactly one cycle.
REQ-013 Throughput SHALL be one operation per 30 cycles; valid_i while ready_o=0 is ignored and not queued.
REQ-014 PREP: unpack sign, exponent and 24-bit significand (hidden bit).
- Denormal inputs are treated as signed zero (DAZ).
- If the dividend significand is less than the divisor significand, shift the dividend left 1 and decrement the exponent.
REQ-015 DIV: restoring radix-2, one quotient bit per cycle; 26 bits = 24 significand + guard + round; sticky = (final remainder != 0).
REQ-016 Biased exponent = eA - eB + 127 - adjust, computed in at least 10-bit signed arithmetic; result sign = sA ^ sB.
REQ-017 ROUND: round-to-nearest-even.
- A significand carry-out renormalizes and increments the exponent.
- Final exponent >= 255: return +/-infinity and set overflow_o.
- Final exponent <= 0: return +/-0 (flush-to-zero) and set underflow_o.
REQ-018 Special cases override the datapath but keep the same latency.
- Any NaN operand returns 7FC00000; invalid_o=1 only if either NaN is signalling.
- 0/0 and inf/inf return 7FC00000 with invalid_o=1.
- Finite nonzero / 0 returns signed infinity with divzero_o=1.
- inf/finite returns signed infinity; finite/inf and 0/nonzero return signed zero; all with flags 0.
REQ-019 result_o and the flags SHALL hold their value from one done_o until the next done_o.

Reset
REQ-020 While rst_i=1 at an edge:
- state becomes IDLE;
- result_o=0, all flags 0, done_o=0, ready_o=1 from the next cycle.
REQ-021 Reset during PREP, DIV, ROUND or DONE SHALL abandon the operation; no done_o is produced for it.

Structure
REQ-022 Package fp32_pkg SHALL hold:
- bias 127, EXP_W=8, MAN_W=23;
- QNAN=7FC00000, POS_INF=7F800000;
- the FSM state enum, the DIV iteration count 26, and the operand-class enum (ZERO, NORMAL, INF, QNAN, SNAN).
REQ-023 One sub-module, fp32_unpack, SHALL classify and unpack a single operand; it is instantiated twice.

Verification
REQ-024 40C00000/40000000 -> 40400000, all flags 0; done_o exactly at E0+29; ready_o low throughout.
REQ-025 3F800000/40400000 -> 3EAAAAAB (RNE); 3F800000/00000000 -> 7F800000 with divzero_o=1; 00000000/00000000 -> 7FC00000 with invalid_o=1.
REQ-026 7F000000/00800000 -> 7F800000 with overflow_o=1; 00800000/40000000 -> 00000000 with underflow_o=1.
REQ-027 7F800001/3F800000 -> 7FC00000 with invalid_o=1; FFC00000/3F800000 -> 7FC00000 with invalid_o=0.
REQ-028 valid_i held high continuously with new operands every cycle: only the operands present at each ready_o=1 edge are processed; one done_o per 30 cycles.
REQ-029 rst_i pulsed at E0+10: no done_o follows; ready_o=1 the next cycle; the next request completes normally.
